// File: rtl/func_code_issuer_if.sv
// Request/code bundle between the requesters, the code issuer and the checker.
// Handshake: a request transfers on a rising edge where valid && ready; code is sampled then.
interface func_code_issuer_if;
    logic       reqA_valid;
    logic [2:0] reqA_code;
    logic       reqA_ready;
    logic       reqB_valid;
    logic [2:0] reqB_code;
    logic       reqB_ready;
    logic [2:0] A;
    logic [2:0] B;
    logic [1:0] S;
    logic [1:0] err;
    logic [1:0] dbg_state;  // [0]: channel A in HOLD, [1]: channel B in HOLD

    modport master (
        output reqA_valid, reqA_code, reqB_valid, reqB_code,
        input  reqA_ready, reqB_ready, A, B, S, err, dbg_state
    );

    modport slave (
        input  reqA_valid, reqA_code, reqB_valid, reqB_code,
        output reqA_ready, reqB_ready, A, B, S, err, dbg_state
    );
endinterface

// File: rtl/func_code_issuer.sv
// Writer of the two functionality codes A/B with per-channel minimum hold and FUNC2 exclusivity.
// Optional blocked-request timeout is enabled by defining FUNC2_TIMEOUT_EN.
module func_code_issuer #(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned TIMEOUT     = 16,
    parameter logic [2:0]  FUNC2_CODE  = 3'b010
) (
    input logic               clk,
    input logic               rst,
    func_code_issuer_if.slave bus
);
    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

    localparam logic [7:0] HOLD_INIT = 8'(HOLD_CYCLES - 1);

    state_t     state_a_q, state_a_d, state_b_q, state_b_d;
    logic [7:0] hold_a_q, hold_a_d, hold_b_q, hold_b_d;
    logic [2:0] code_a_q, code_a_d, code_b_q, code_b_d;
    logic [1:0] s_q, s_d;
    logic       blk_a, blk_b, expire_a, expire_b;
    logic       ready_a, ready_b, take_a, take_b;

    // B also yields when A grabs FUNC2 on this same edge, so both can never own it at once.
    assign blk_a = (bus.reqA_code == FUNC2_CODE) && (code_b_q == FUNC2_CODE);
    assign blk_b = (bus.reqB_code == FUNC2_CODE) &&
                   ((code_a_q == FUNC2_CODE) || (take_a && (bus.reqA_code == FUNC2_CODE)));

    assign ready_a = (state_a_q == IDLE) && (!blk_a || expire_a);
    assign ready_b = (state_b_q == IDLE) && (!blk_b || expire_b);
    assign take_a  = bus.reqA_valid && ready_a && !expire_a;
    assign take_b  = bus.reqB_valid && ready_b && !expire_b;

`ifdef FUNC2_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_V = 8'(TIMEOUT);

    logic [7:0] wait_a_q, wait_a_d, wait_b_q, wait_b_d;
    logic [1:0] err_q, err_d;

    // The expiry cycle raises ready but the request is dropped, not transferred.
    assign expire_a = (state_a_q == IDLE) && blk_a && (wait_a_q == TIMEOUT_V);
    assign expire_b = (state_b_q == IDLE) && blk_b && (wait_b_q == TIMEOUT_V);

    always_comb begin
        wait_a_d = 8'd0;
        wait_b_d = 8'd0;
        if (bus.reqA_valid && (state_a_q == IDLE) && blk_a && !expire_a)
            wait_a_d = wait_a_q + 8'd1;
        if (bus.reqB_valid && (state_b_q == IDLE) && blk_b && !expire_b)
            wait_b_d = wait_b_q + 8'd1;
        err_d = err_q | {bus.reqB_valid && expire_b, bus.reqA_valid && expire_a};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_a_q <= 8'd0;
            wait_b_q <= 8'd0;
            err_q    <= 2'b00;
        end else begin
            wait_a_q <= wait_a_d;
            wait_b_q <= wait_b_d;
            err_q    <= err_d;
        end
    end

    assign bus.err = err_q;
`else
    assign expire_a = 1'b0;
    assign expire_b = 1'b0;
    assign bus.err  = 2'b00;
`endif

    always_comb begin
        state_a_d = state_a_q;
        state_b_d = state_b_q;
        hold_a_d  = hold_a_q;
        hold_b_d  = hold_b_q;
        code_a_d  = code_a_q;
        code_b_d  = code_b_q;

        if (state_a_q == IDLE) begin
            if (take_a) begin
                code_a_d  = bus.reqA_code;
                state_a_d = HOLD;
                hold_a_d  = HOLD_INIT;
            end
        end else if (hold_a_q == 8'd0) begin
            state_a_d = IDLE;
        end else begin
            hold_a_d = hold_a_q - 8'd1;
        end

        if (state_b_q == IDLE) begin
            if (take_b) begin
                code_b_d  = bus.reqB_code;
                state_b_d = HOLD;
                hold_b_d  = HOLD_INIT;
            end
        end else if (hold_b_q == 8'd0) begin
            state_b_d = IDLE;
        end else begin
            hold_b_d = hold_b_q - 8'd1;
        end

        // Ownership flags follow the codes being registered on this edge.
        s_d = {(code_b_d == FUNC2_CODE) && (code_a_d != FUNC2_CODE),
               (code_a_d == FUNC2_CODE) && (code_b_d != FUNC2_CODE)};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_a_q <= IDLE;
            state_b_q <= IDLE;
            hold_a_q  <= 8'd0;
            hold_b_q  <= 8'd0;
            code_a_q  <= 3'd0;
            code_b_q  <= 3'd0;
            s_q       <= 2'b00;
        end else begin
            state_a_q <= state_a_d;
            state_b_q <= state_b_d;
            hold_a_q  <= hold_a_d;
            hold_b_q  <= hold_b_d;
            code_a_q  <= code_a_d;
            code_b_q  <= code_b_d;
            s_q       <= s_d;
        end
    end

    assign bus.reqA_ready = ready_a;
    assign bus.reqB_ready = ready_b;
    assign bus.A          = code_a_q;
    assign bus.B          = code_b_q;
    assign bus.S          = s_q;
    assign bus.dbg_state  = {state_b_q == HOLD, state_a_q == HOLD};
endmodule

// File: tb/tb_func_code_issuer.sv
// Directed bench for func_code_issuer: cycle model compared every cycle plus literal checkpoints.
module tb_func_code_issuer;
  localparam int         H   = 4;
  localparam int         TMO = 16;
  localparam logic [2:0] F   = 3'b010;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  func_code_issuer_if bus();

  func_code_issuer #(.HOLD_CYCLES(H), .TIMEOUT(TMO), .FUNC2_CODE(F)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model: codes, remaining ready-low cycles, blocked-wait counts
  logic [2:0] m_a, m_b, n_a, n_b;
  int         m_hold_a, m_hold_b, n_hold_a, n_hold_b;
  int         m_wait_a, m_wait_b, n_wait_a, n_wait_b;
  logic [1:0] m_err, n_err;
  logic       live, idle_a, idle_b, mblk_a, mblk_b, mexp_a, mexp_b;
  logic       e_rdy_a, e_rdy_b, mtake_a, mtake_b;

  always begin
    @(negedge clk);
    live = !rst;
    if (live) begin
      idle_a = (m_hold_a == 0);
      idle_b = (m_hold_b == 0);
      mblk_a = (bus.reqA_code == F) && (m_b == F);
`ifdef FUNC2_TIMEOUT_EN
      mexp_a = idle_a && mblk_a && (m_wait_a == TMO);
`else
      mexp_a = 1'b0;
`endif
      e_rdy_a = idle_a && (!mblk_a || mexp_a);
      mtake_a = bus.reqA_valid && e_rdy_a && !mexp_a;
      mblk_b = (bus.reqB_code == F) && ((m_a == F) || (mtake_a && bus.reqA_code == F));
`ifdef FUNC2_TIMEOUT_EN
      mexp_b = idle_b && mblk_b && (m_wait_b == TMO);
`else
      mexp_b = 1'b0;
`endif
      e_rdy_b = idle_b && (!mblk_b || mexp_b);
      mtake_b = bus.reqB_valid && e_rdy_b && !mexp_b;

      check("ready_a", 8'(bus.reqA_ready), 8'(e_rdy_a));
      check("ready_b", 8'(bus.reqB_ready), 8'(e_rdy_b));
      check("code_a", 8'(bus.A), 8'(m_a));
      check("code_b", 8'(bus.B), 8'(m_b));
      check("own_s", 8'(bus.S), 8'({(m_b == F) && (m_a != F), (m_a == F) && (m_b != F)}));
      check("err", 8'(bus.err), 8'(m_err));
      check("dbg_state", 8'(bus.dbg_state), 8'({m_hold_b != 0, m_hold_a != 0}));

      n_a      = mtake_a ? bus.reqA_code : m_a;
      n_b      = mtake_b ? bus.reqB_code : m_b;
      n_hold_a = mtake_a ? H : (m_hold_a > 0 ? m_hold_a - 1 : 0);
      n_hold_b = mtake_b ? H : (m_hold_b > 0 ? m_hold_b - 1 : 0);
      n_wait_a = (bus.reqA_valid && idle_a && mblk_a && !mexp_a) ? m_wait_a + 1 : 0;
      n_wait_b = (bus.reqB_valid && idle_b && mblk_b && !mexp_b) ? m_wait_b + 1 : 0;
      n_err    = m_err | {bus.reqB_valid && mexp_b, bus.reqA_valid && mexp_a};
    end
    @(posedge clk);
    if (rst) begin
      m_a = 3'd0; m_b = 3'd0; m_hold_a = 0; m_hold_b = 0;
      m_wait_a = 0; m_wait_b = 0; m_err = 2'b00;
    end else if (live) begin
      m_a = n_a; m_b = n_b; m_hold_a = n_hold_a; m_hold_b = n_hold_b;
      m_wait_a = n_wait_a; m_wait_b = n_wait_b; m_err = n_err;
    end
  end

  // ---------------- driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.reqA_valid = 1'b1; bus.reqA_code = F;
    bus.reqB_valid = 1'b1; bus.reqB_code = F;
    step();
    step();
    rst = 1'b0;
    bus.reqA_valid = 1'b0; bus.reqA_code = 3'd0;
    bus.reqB_valid = 1'b0; bus.reqB_code = 3'd0;
  endtask

  task automatic wait_ready(input bit ch, input int max_cycles);
    bit ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if ((ch ? bus.reqB_ready : bus.reqA_ready) === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    check(ch ? "wait_ready_b" : "wait_ready_a", 8'(ok), 8'd1);
  endtask

  // Present a request, wait for acceptance, then drop valid after the transfer edge.
  task automatic issue(input bit ch, input logic [2:0] code);
    if (!ch) begin bus.reqA_valid = 1'b1; bus.reqA_code = code; end
    else     begin bus.reqB_valid = 1'b1; bus.reqB_code = code; end
    wait_ready(ch, 20);
    step();
    if (!ch) bus.reqA_valid = 1'b0;
    else     bus.reqB_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence
  initial begin
    int pulse_cycle;
    bus.reqA_valid = 1'b0; bus.reqA_code = 3'd0;
    bus.reqB_valid = 1'b0; bus.reqB_code = 3'd0;

    // reset with both valids high
    do_reset();
    @(negedge clk);
    check("rst_A", 8'(bus.A), 8'd0);
    check("rst_B", 8'(bus.B), 8'd0);
    check("rst_S", 8'(bus.S), 8'd0);
    check("rst_err", 8'(bus.err), 8'd0);
    check("rst_ready_a", 8'(bus.reqA_ready), 8'd1);
    check("rst_ready_b", 8'(bus.reqB_ready), 8'd1);

    // simple issue: ready low exactly 4 cycles, high in the 5th
    step();
    bus.reqA_valid = 1'b1; bus.reqA_code = 3'b101;
    step();
    bus.reqA_valid = 1'b0;
    @(negedge clk);
    check("issue_A", 8'(bus.A), 8'h05);
    check("issue_S", 8'(bus.S), 8'h00);
    check("hold_c1", 8'(bus.reqA_ready), 8'd0);
    for (int i = 2; i <= 4; i++) begin
      step();
      @(negedge clk);
      check("hold_low", 8'(bus.reqA_ready), 8'd0);
    end
    step();
    @(negedge clk);
    check("hold_release", 8'(bus.reqA_ready), 8'd1);

    // exclusion: A owns FUNC2, B blocked until A moves to 011
    step();
    issue(1'b0, F);
    @(negedge clk);
    check("excl_A", 8'(bus.A), 8'(F));
    check("excl_S01", 8'(bus.S), 8'h01);
    step();
    bus.reqB_valid = 1'b1; bus.reqB_code = F;
    @(negedge clk);
    check("excl_b_blocked", 8'(bus.reqB_ready), 8'd0);
    step();
    issue(1'b0, 3'b011);
    bus.reqB_valid = 1'b1;
    @(negedge clk);
    check("excl_A_moved", 8'(bus.A), 8'h03);
    check("excl_S00", 8'(bus.S), 8'h00);
    check("excl_b_release", 8'(bus.reqB_ready), 8'd1);
    step();
    bus.reqB_valid = 1'b0;
    @(negedge clk);
    check("excl_B", 8'(bus.B), 8'(F));
    check("excl_S10", 8'(bus.S), 8'h02);

    // A blocked while B owns FUNC2, released when B moves to 000
    step();
    bus.reqA_valid = 1'b1; bus.reqA_code = F;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("a_blocked", 8'(bus.reqA_ready), 8'd0);
      step();
    end
    issue(1'b1, 3'b000);
    @(negedge clk);
    check("b_moved", 8'(bus.B), 8'h00);
    check("a_release", 8'(bus.reqA_ready), 8'd1);
    step();
    bus.reqA_valid = 1'b0;
    @(negedge clk);
    check("a_took_f2", 8'(bus.A), 8'(F));
    check("a_took_S", 8'(bus.S), 8'h01);

    // same-code request still restarts HOLD
    step();
    issue(1'b0, F);
    @(negedge clk);
    check("same_code_A", 8'(bus.A), 8'(F));
    check("same_code_hold", 8'(bus.reqA_ready), 8'd0);

    // simultaneous FUNC2 requests from reset: A wins
    step();
    do_reset();
    bus.reqA_valid = 1'b1; bus.reqA_code = F;
    bus.reqB_valid = 1'b1; bus.reqB_code = F;
    @(negedge clk);
    check("sim_ready_a", 8'(bus.reqA_ready), 8'd1);
    check("sim_ready_b", 8'(bus.reqB_ready), 8'd0);
    step();
    bus.reqA_valid = 1'b0;
    @(negedge clk);
    check("sim_A", 8'(bus.A), 8'(F));
    check("sim_S", 8'(bus.S), 8'h01);
    check("sim_B", 8'(bus.B), 8'h00);
    check("sim_b_stall", 8'(bus.reqB_ready), 8'd0);

`ifdef FUNC2_TIMEOUT_EN
    // B blocked cycles 0..15 (cycle 0 = simultaneous cycle); pulse in cycle 16
    pulse_cycle = -1;
    for (int c = 2; c < 40; c++) begin
      step();
      @(negedge clk);
      if (bus.reqB_ready === 1'b1) begin
        pulse_cycle = c;
        break;
      end
    end
    check("tmo_pulse_cycle", 8'(pulse_cycle), 8'(TMO));
    step();
    @(negedge clk);
    check("tmo_B_unchanged", 8'(bus.B), 8'h00);
    check("tmo_err", 8'(bus.err), 8'h02);
    check("tmo_no_hold", 8'(bus.reqB_ready), 8'd0);
    step();
    bus.reqB_valid = 1'b0;
    repeat (5) step();
    @(negedge clk);
    check("tmo_err_sticky", 8'(bus.err), 8'h02);
`else
    pulse_cycle = 0;
    repeat (100) begin
      step();
      @(negedge clk);
      if (bus.reqB_ready === 1'b1) pulse_cycle++;
    end
    check("wait_no_ready", 8'(pulse_cycle), 8'd0);
    check("wait_B", 8'(bus.B), 8'h00);
    check("wait_err", 8'(bus.err), 8'h00);
    step();
    bus.reqB_valid = 1'b0;
`endif

    // reset in the middle of a HOLD
    step();
    issue(1'b0, 3'b110);
    @(negedge clk);
    check("mid_A", 8'(bus.A), 8'h06);
    step();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_A", 8'(bus.A), 8'h00);
    check("mid_rst_S", 8'(bus.S), 8'h00);
    check("mid_rst_ready_a", 8'(bus.reqA_ready), 8'd1);
    check("mid_rst_err", 8'(bus.err), 8'h00);

    step();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
